// File: rtl/arbiter_mux_8to1.sv
// arbiter_mux_8to1
//   Eight-source round-robin arbitrating multiplexer with a one-word output
//   register and a valid/ready handshake on the output side.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   Req[7:0]  in   Req[k]=1: source k offers In{k}
//   In0..In7  in   N-bit source words
//   Grant     out  one-hot, combinational; marks the source captured this cycle
//   Out       out  registered output word
//   Source    out  index of the source that supplied Out
//   OutValid  out  Out/Source hold an undelivered word
//   OutReady  in   consumer takes Out this cycle when OutValid=1
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no undelivered word; any request loads at once
// FULL  | Out/Source valid; waits for OutReady to free or
//       | refill the register
module arbiter_mux_8to1 #(
    parameter int N = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [7:0]   Req,
    input  logic [N-1:0] In0,
    input  logic [N-1:0] In1,
    input  logic [N-1:0] In2,
    input  logic [N-1:0] In3,
    input  logic [N-1:0] In4,
    input  logic [N-1:0] In5,
    input  logic [N-1:0] In6,
    input  logic [N-1:0] In7,
    output logic [7:0]   Grant,
    output logic [N-1:0] Out,
    output logic [2:0]   Source,
    output logic         OutValid,
    input  logic         OutReady
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]   state;
    logic [2:0]   last;
    logic [2:0]   sel;
    logic         load;
    logic [N-1:0] ins [8];

    assign ins[0] = In0;
    assign ins[1] = In1;
    assign ins[2] = In2;
    assign ins[3] = In3;
    assign ins[4] = In4;
    assign ins[5] = In5;
    assign ins[6] = In6;
    assign ins[7] = In7;

    assign OutValid = (state == FULL);

    // Scan last+1, last+2, ... and finally last itself; the 3-bit sum wraps
    // modulo 8. The first hit wins.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        sel   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = last + 3'(i) + 3'd1;
            if (!found && Req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // A word can be taken whenever the register is free or being emptied
    // in the same cycle, which keeps throughput at one word per cycle.
    assign load  = ((state == EMPTY) || OutReady) && (Req != 8'h00);
    assign Grant = load ? (8'h01 << sel) : 8'h00;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= EMPTY;
            Out    <= '0;
            Source <= 3'd0;
            last   <= 3'd7;
        end else if (load) begin
            state  <= FULL;
            Out    <= ins[sel];
            Source <= sel;
            last   <= sel;
        end else if ((state == FULL) && OutReady) begin
            state  <= EMPTY;
        end
    end

endmodule

// File: tb/tb_arbiter_mux_8to1.sv
module tb_arbiter_mux_8to1;

    logic        Clk;
    logic        Reset;
    logic [7:0]  Req;
    logic [15:0] In0, In1, In2, In3, In4, In5, In6, In7;
    logic [7:0]  Grant;
    logic [15:0] Out;
    logic [2:0]  Source;
    logic        OutValid;
    logic        OutReady;

    int n_checks;
    int n_fail;

    arbiter_mux_8to1 #(.N(16)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .In0      (In0),
        .In1      (In1),
        .In2      (In2),
        .In3      (In3),
        .In4      (In4),
        .In5      (In5),
        .In6      (In6),
        .In7      (In7),
        .Grant    (Grant),
        .Out      (Out),
        .Source   (Source),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs
    // sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        Req      = 8'h00;
        OutReady = 1'b0;
        {In0, In1, In2, In3, In4, In5, In6, In7} = '0;

        step();
        step();
        chk("rst_out",    32'(Out),      32'h0);
        chk("rst_source", 32'(Source),   32'h0);
        chk("rst_valid",  32'(OutValid), 32'h0);
        chk("rst_grant",  32'(Grant),    32'h0);
        Reset = 1'b0;
        #1;

        // Single source
        Req = 8'h08; In3 = 16'hBEEF; OutReady = 1'b1;
        #1;
        chk("single_grant", 32'(Grant), 32'h08);
        step();
        Req = 8'h00;
        #1;
        chk("single_out",    32'(Out),      32'hBEEF);
        chk("single_source", 32'(Source),   32'h3);
        chk("single_valid",  32'(OutValid), 32'h1);
        chk("drain_grant",   32'(Grant),    32'h00);
        step();
        chk("drain_valid", 32'(OutValid), 32'h0);
        chk("drain_hold",  32'(Out),      32'hBEEF);
        OutReady = 1'b0;
        #1;
        chk("empty_idle_grant", 32'(Grant), 32'h00);

        // Restart arbitration at source 0 with an async pulse
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        #1;

        // Round-robin with all sources
        In0 = 16'h1000; In1 = 16'h1001; In2 = 16'h1002; In3 = 16'h1003;
        In4 = 16'h1004; In5 = 16'h1005; In6 = 16'h1006; In7 = 16'h1007;
        Req = 8'hFF; OutReady = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rr_grant%0d", i), 32'(Grant), 32'(8'h01 << (i % 8)));
            step();
            chk($sformatf("rr_source%0d", i), 32'(Source), 32'(i % 8));
            chk($sformatf("rr_out%0d", i), 32'(Out), 32'h1000 + 32'(i % 8));
            chk($sformatf("rr_valid%0d", i), 32'(OutValid), 32'h1);
        end

        // Backpressure: load source 2 (Last=1 -> scan starts at 2)
        Req = 8'h04;
        #1;
        chk("bp_load_grant", 32'(Grant), 32'h04);
        step();
        chk("bp_load_out", 32'(Out), 32'h1002);
        OutReady = 1'b0; Req = 8'h30;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_grant%0d", i), 32'(Grant), 32'h00);
            step();
            chk($sformatf("bp_out%0d", i), 32'(Out), 32'h1002);
            chk($sformatf("bp_source%0d", i), 32'(Source), 32'h2);
            chk($sformatf("bp_valid%0d", i), 32'(OutValid), 32'h1);
        end
        OutReady = 1'b1;
        #1;
        chk("bp_release_grant", 32'(Grant), 32'h10);
        step();
        chk("bp_release_out",    32'(Out),    32'h1004);
        chk("bp_release_source", 32'(Source), 32'h4);

        // Wrap-around priority
        Req = 8'h40;
        #1;
        chk("wrap_g6", 32'(Grant), 32'h40);
        step();
        chk("wrap_s6", 32'(Source), 32'h6);
        Req = 8'h41;
        #1;
        chk("wrap_g0_first", 32'(Grant), 32'h01);
        step();
        chk("wrap_s0",   32'(Source), 32'h0);
        chk("wrap_out0", 32'(Out),    32'h1000);
        Req = 8'h80;
        #1;
        chk("wrap_g7", 32'(Grant), 32'h80);
        step();
        chk("wrap_s7", 32'(Source), 32'h7);
        #1;
        chk("wrap_g7_again", 32'(Grant), 32'h80);
        step();
        chk("wrap_s7_again", 32'(Source), 32'h7);

        // Simultaneous consume and load
        Req = 8'h02; In1 = 16'h00AA;
        #1;
        chk("sim_grant", 32'(Grant), 32'h02);
        step();
        chk("sim_valid",  32'(OutValid), 32'h1);
        chk("sim_out",    32'(Out),      32'h00AA);
        chk("sim_source", 32'(Source),   32'h1);

        // Mid-operation reset (Last=1 -> source 5 reached after 2,3,4 empty)
        Req = 8'h20;
        #1;
        chk("mid_grant5", 32'(Grant), 32'h20);
        step();
        chk("mid_source5", 32'(Source), 32'h5);
        Req = 8'h00; OutReady = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_out",    32'(Out),      32'h0);
        chk("mid_rst_source", 32'(Source),   32'h0);
        chk("mid_rst_valid",  32'(OutValid), 32'h0);
        Reset = 1'b0;
        Req = 8'hFF; OutReady = 1'b1;
        #1;
        chk("mid_first_grant", 32'(Grant), 32'h01);
        step();
        chk("mid_first_source", 32'(Source), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_mux_8to1.md
# arbiter_mux_8to1

An N-bit, 8-input round-robin arbitrating multiplexer with a one-word output register and valid/ready handshake. It is the collecting counterpart of the 1:8 de-multiplexer: eight independent sources each offer a word, the block grants one per transfer, and it presents that word on a single shared output. It sits in front of shared datapath resources such as the bus driver and memory write port, where several units contend for one destination.

## Interface
Parameters:
- N, 16, data width of each input word and of Out.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  8  Req[k]=1 means source k offers In{k}.
- In0..In7  input  N each  source data words.
- Grant  output  8  one-hot, combinational; Grant[k]=1 in the cycle In{k} is captured.
- Out  output  N  registered output word.
- Source  output  3  index of the source that supplied Out.
- OutValid  output  1  Out/Source hold an undelivered word.
- OutReady  input  1  consumer accepts Out this cycle when OutValid=1.

## Operation
- State: output register (Out, Source), OutValid flag, 3-bit round-robin pointer Last.
- Two states: EMPTY (OutValid=0) and FULL (OutValid=1).
- Load condition L = (OutValid==0 || OutReady==1) && (Req != 0).
- Arbitration: the selected index is the first k with Req[k]=1, scanning Last+1, Last+2, ... mod 8 and ending at Last itself. Wrap-around 7->0 is modular.
- When L=1: Grant[sel]=1 and all other Grant bits are 0. At the clock edge Out<=In{sel}, Source<=sel, OutValid<=1, Last<=sel.
- When L=0: Grant=8'h00.
- FULL, OutReady=1, Req=0: at the edge OutValid<=0. Out and Source keep their last values.
- FULL, OutReady=0: Out, Source, OutValid and Last are frozen. Grant=0.
- EMPTY, Req=0: nothing changes. OutReady is ignored.
- Simultaneous consume and load (FULL, OutReady=1, Req!=0): the old word is delivered and the new word is loaded at the same edge, so OutValid stays 1. This gives a throughput of one word per cycle.
- Sources must hold Req and In{k} stable until they see Grant[k]. A source may drop Req without having been granted; its word is then not transferred.
- Grant depends combinationally on Req, OutValid, OutReady and Last. It does not depend on In.

## Timing
- Reset values, applied asynchronously and held while Reset=1:
  - Out=0, Source=0, OutValid=0, Last=7 (so source 0 has first priority).
  - Grant=0 whenever OutValid=0 and Req=0.
- Latency: a word captured on edge t appears on Out with OutValid=1 in the cycle after edge t. That is one cycle from Grant to OutValid.
- Fairness: with all eight Req held high and OutReady=1, grants rotate 0,1,...,7,0. Any continuously requesting source is granted within 8 transfers.
- Reset asserted mid-operation discards the word in Out. Deasserting Reset restarts arbitration at source 0.
- No combinational path from In to Out.

## Test plan
- Reset then single source: Reset pulse, Req=8'h08, In3=16'hBEEF, OutReady=1 -> Grant=8'h08 in the first cycle. Next cycle Out=16'hBEEF, Source=3, OutValid=1. With Req=0 afterwards, OutValid=0 one cycle later.
- Round-robin with all sources: Req=8'hFF, In{k}=16'h1000+k, OutReady=1 for 10 cycles -> Source sequence is 0,1,2,3,4,5,6,7,0,1 and OutValid=1 continuously from the second cycle.
- Backpressure: hold FULL with Out=16'h1002, OutReady=0 for 4 cycles while Req=8'h30 -> Out, Source and OutValid are unchanged and Grant=0. When OutReady rises, Grant=8'h10 that cycle, then Out=In4.
- Wrap-around priority: Last=6 (after a grant to source 6), Req=8'h41 -> source 0 is granted before source 6. With Last=7, Req=8'h80 -> source 7 is granted again.
- Simultaneous consume/load: FULL with OutReady=1 and Req=8'h02, In1=16'h00AA -> OutValid never drops and Out becomes 16'h00AA on the next edge.
- Mid-operation reset: FULL with Source=5, assert Reset asynchronously between edges -> Out=0, Source=0 and OutValid=0 immediately. After release with Req=8'hFF, the first grant is 8'h01.
